xgmii_tx_framer: RTL and testbench
==================================

Name: xgmii_tx_framer

Overview:
- Upstream stage of the XGMII CRC-32 checker.
- Converts a 64-bit valid/ready payload stream into a framed XGMII stream: start/preamble/SFD word, payload words, terminate word, then inter-frame idles.
- Its xgmii_data/xgmii_ctrl outputs drive the CRC-32 block directly.
- The XGMII side cannot stall: a payload gap mid-frame aborts the frame with error codes.

Parameters:
- IFG_WORDS, 2, minimum number of all-idle words emitted after the word that carries /T/ (range 1..15).

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous, active-low reset.
- s_data  in  64  payload bytes; lane i = s_data[8i+7:8i]; lane 0 is first on the wire.
- s_keep  in  4  number of valid bytes on the last beat (1..8); ignored when s_last=0.
- s_last  in  1  marks the final payload beat.
- s_valid  in  1  payload beat valid.
- s_ready  out  1  framer accepts the beat this cycle.
- xgmii_data  out  64  XGMII data lanes (registered).
- xgmii_ctrl  out  8  XGMII control flags, bit i for lane i (registered).
- frame_done_o  out  1  one-cycle pulse, registered with the /T/ word of a good frame.
- underrun_o  out  1  one-cycle pulse, registered with the /E/ word of an aborted frame.

Behaviour:
- Codes: idle 0x07, start 0xFB, terminate 0xFD, error 0xFE, preamble 0x55, SFD 0xD5.
- Idle word: data 0x0707070707070707, ctrl 0xFF.
- Reset values: xgmii_data = idle word, xgmii_ctrl 0xFF, s_ready 0, frame_done_o 0, underrun_o 0, FSM in IDLE, IFG counter 0. Reset mid-frame returns to idle output immediately, with no /T/ emitted.
- All outputs except s_ready are registered; each output word appears one clk after the decision that produced it. s_ready is combinational from state.
- IDLE (s_ready=0): emit idle. If s_valid=1, next state is START.
- START (s_ready=0): emit start word, ctrl 0x01:
  - lane 0 = 0xFB;
  - lanes 1-6 = 0x55;
  - lane 7 = 0xD5.
  - Next state is DATA.
- DATA (s_ready=1):
  - s_valid=1, s_last=0: emit s_data with ctrl 0x00; stay in DATA.
  - s_valid=1, s_last=1, k = s_keep with 0 or >8 treated as 8:
    - k<8: emit lanes 0..k-1 = data (ctrl 0); lane k = 0xFD (ctrl 1); lanes k+1..7 = 0x07 (ctrl 1). Pulse frame_done_o, load IFG counter, go to IFG.
    - k=8: emit full data word (ctrl 0x00) and go to TERM.
  - s_valid=0: underrun. Emit 0xFE in all lanes (ctrl 0xFF) and pulse underrun_o. Go to DROP.
- TERM (s_ready=0): emit data 0x07070707070707FD, ctrl 0xFF. Pulse frame_done_o, load IFG counter, go to IFG.
- IFG (s_ready=0): emit idle, decrement counter. After exactly IFG_WORDS idle words, go to IDLE. The earliest next START word follows IFG_WORDS+1 idle-or-later cycles, since IDLE itself emits one idle.
- DROP (s_ready=1): emit idle. Accept and discard beats until a beat with s_valid=1, s_last=1 is consumed, then load IFG counter and go to IFG. An abort is never reported as frame_done_o.
- Single-beat frame (first beat has s_last=1) is legal: START, then /T/ word.
- Back-to-back frames: s_valid held high during IFG/IDLE is not consumed, because s_ready=0.

Decomposition:
- xgmii_pkg holds:
  - the code constants CODE_IDLE, CODE_START, CODE_TERM, CODE_ERR, PREAMBLE_BYTE, SFD_BYTE, IDLE_WORD;
  - the FSM enum typedef tx_state_t {IDLE, START, DATA, TERM, IFG, DROP}.
- The CRC-32 block shares CODE_START and CODE_TERM from this package.
- Sub-module xgmii_term_encode (combinational): inputs data[63:0] and k[3:0]; outputs the terminate-word data/ctrl for k=0..7, where k=0 gives 0x07070707070707FD / 0xFF.

Test Plan:
- Reset, then s_valid=0 for 10 cycles -> xgmii_data=0x0707070707070707, ctrl=0xFF every cycle; s_ready=0.
- 3-beat frame with last s_keep=3 -> start word 0xD5555555555555FB / ctrl 0x01; two data words with ctrl 0x00; term word lanes0-2 data, lane3 0xFD, lanes4-7 0x07 / ctrl 0xF8 with frame_done_o=1; then 2 idle words.
- 1-beat frame with s_keep=8 -> start word; data word with ctrl 0x00; then 0x07070707070707FD / ctrl 0xFF with frame_done_o; then IFG idles.
- Drop s_valid for 1 cycle in beat 2 of a 4-beat frame -> 0xFEFEFEFEFEFEFEFE / ctrl 0xFF with underrun_o=1; remaining beats consumed while idle is emitted; no frame_done_o; next frame starts after IFG.
- Two frames back-to-back with s_valid held high -> between the /T/ word and the next start word exactly IFG_WORDS+1 idle words (3 at default).
- rstn asserted during DATA -> outputs return to the idle word asynchronously; after release the next frame is fully correct.

Source files
------------

// File: rtl/xgmii_pkg.sv
// Shared XGMII control codes and framer state type. The CRC-32 checker
// downstream uses CODE_START and CODE_TERM from here as well.
package xgmii_pkg;

  localparam logic [7:0] CODE_IDLE     = 8'h07;
  localparam logic [7:0] CODE_START    = 8'hFB;
  localparam logic [7:0] CODE_TERM     = 8'hFD;
  localparam logic [7:0] CODE_ERR      = 8'hFE;
  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  localparam logic [63:0] IDLE_WORD  = {8{CODE_IDLE}};
  localparam logic [63:0] START_WORD = {SFD_BYTE, {6{PREAMBLE_BYTE}}, CODE_START};
  localparam logic [63:0] ERR_WORD   = {8{CODE_ERR}};
  localparam logic [63:0] TERM_WORD  = {{7{CODE_IDLE}}, CODE_TERM};

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    TERM,
    IFG,
    DROP
  } tx_state_t;

  // A last-beat byte count of 0 or above 8 means a full beat.
  function automatic logic [3:0] norm_keep(input logic [3:0] keep);
    return ((keep == 4'd0) || (keep > 4'd8)) ? 4'd8 : keep;
  endfunction

endpackage

// File: rtl/xgmii_term_encode.sv
// Builds the /T/ word for a final beat carrying k (0..7) valid bytes:
// data lanes, then the terminate code, then idle fill.
module xgmii_term_encode
  import xgmii_pkg::*;
(
  input  logic [63:0] data,
  input  logic [3:0]  k,
  output logic [63:0] term_data,
  output logic [7:0]  term_ctrl
);

  always_comb begin
    term_data = IDLE_WORD;
    term_ctrl = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < k) begin
        term_data[8*i +: 8] = data[8*i +: 8];
        term_ctrl[i]        = 1'b0;
      end else if (4'(i) == k) begin
        term_data[8*i +: 8] = CODE_TERM;
      end
    end
  end

endmodule

// File: rtl/xgmii_tx_framer.sv
// Frames a 64-bit valid/ready payload stream onto XGMII. The XGMII side never
// stalls, so a missing beat mid-frame aborts the frame with an /E/ word.
module xgmii_tx_framer
  import xgmii_pkg::*;
#(
  parameter int unsigned IFG_WORDS = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [63:0] s_data,
  input  logic [3:0]  s_keep,
  input  logic        s_last,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [63:0] xgmii_data,
  output logic [7:0]  xgmii_ctrl,
  output logic        frame_done_o,
  output logic        underrun_o
);

  // Handshake: a beat transfers on a rising clk edge where s_valid && s_ready.
  // s_ready depends only on state; s_valid must not wait for s_ready.

  localparam logic [3:0] IFG_LOAD = 4'(IFG_WORDS);

  tx_state_t   state_q, state_d;
  logic [63:0] data_q, data_d;
  logic [7:0]  ctrl_q, ctrl_d;
  logic        done_q, done_d;
  logic        under_q, under_d;
  logic [3:0]  ifg_cnt_q, ifg_cnt_d;

  logic [3:0]  keep_n;
  logic [63:0] term_data;
  logic [7:0]  term_ctrl;

  assign keep_n = norm_keep(s_keep);

  xgmii_term_encode u_term_encode (
    .data      (s_data),
    .k         (keep_n),
    .term_data (term_data),
    .term_ctrl (term_ctrl)
  );

  always_comb begin
    state_d   = state_q;
    data_d    = IDLE_WORD;
    ctrl_d    = 8'hFF;
    done_d    = 1'b0;
    under_d   = 1'b0;
    ifg_cnt_d = ifg_cnt_q;
    s_ready   = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_valid) state_d = START;
      end
      START: begin
        data_d  = START_WORD;
        ctrl_d  = 8'h01;
        state_d = DATA;
      end
      DATA: begin
        s_ready = 1'b1;
        if (!s_valid) begin
          data_d  = ERR_WORD;
          under_d = 1'b1;
          state_d = DROP;
        end else if (!s_last) begin
          data_d = s_data;
          ctrl_d = 8'h00;
        end else if (keep_n == 4'd8) begin
          // A full last beat leaves no lane for /T/; it goes in the next word.
          data_d  = s_data;
          ctrl_d  = 8'h00;
          state_d = TERM;
        end else begin
          data_d    = term_data;
          ctrl_d    = term_ctrl;
          done_d    = 1'b1;
          ifg_cnt_d = IFG_LOAD;
          state_d   = IFG;
        end
      end
      TERM: begin
        data_d    = TERM_WORD;
        done_d    = 1'b1;
        ifg_cnt_d = IFG_LOAD;
        state_d   = IFG;
      end
      IFG: begin
        ifg_cnt_d = ifg_cnt_q - 4'd1;
        if (ifg_cnt_q <= 4'd1) state_d = IDLE;
      end
      DROP: begin
        // Swallow the rest of the aborted frame while the wire stays idle.
        s_ready = 1'b1;
        if (s_valid && s_last) begin
          ifg_cnt_d = IFG_LOAD;
          state_d   = IFG;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      data_q    <= IDLE_WORD;
      ctrl_q    <= 8'hFF;
      done_q    <= 1'b0;
      under_q   <= 1'b0;
      ifg_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      ctrl_q    <= ctrl_d;
      done_q    <= done_d;
      under_q   <= under_d;
      ifg_cnt_q <= ifg_cnt_d;
    end
  end

  assign xgmii_data   = data_q;
  assign xgmii_ctrl   = ctrl_q;
  assign frame_done_o = done_q;
  assign underrun_o   = under_q;

endmodule

// File: tb/tb_xgmii_tx_framer.sv
// Bench for xgmii_tx_framer: random frames against a byte-stream model of the
// XGMII framing rules.
module tb_xgmii_tx_framer;

  localparam int IFG = 2;
  localparam logic [63:0] IDLE_W  = 64'h0707070707070707;
  localparam logic [63:0] START_W = 64'hD5555555555555FB;
  localparam logic [63:0] ERR_W   = 64'hFEFEFEFEFEFEFEFE;
  localparam logic [73:0] IDLE_E  = {2'b00, 8'hFF, IDLE_W};

  logic        clk, rstn;
  logic [63:0] s_data;
  logic [3:0]  s_keep;
  logic        s_last, s_valid, s_ready;
  logic [63:0] xgmii_data;
  logic [7:0]  xgmii_ctrl;
  logic        frame_done_o, underrun_o;

  xgmii_tx_framer #(.IFG_WORDS(IFG)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .s_data       (s_data),
    .s_keep       (s_keep),
    .s_last       (s_last),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .xgmii_data   (xgmii_data),
    .xgmii_ctrl   (xgmii_ctrl),
    .frame_done_o (frame_done_o),
    .underrun_o   (underrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observed words: {underrun, done, ctrl, data}.
  logic [73:0] got_q[$];
  logic [73:0] exp_q[$];
  bit          cap_en = 1'b0;

  always @(negedge clk)
    if (cap_en) got_q.push_back({underrun_o, frame_done_o, xgmii_ctrl, xgmii_data});

  logic [63:0] b_data[$];
  logic [3:0]  b_keep[$];
  bit          b_last[$];
  logic [7:0]  pay_q[$];
  int          gap_idx = -1;

  // Frame on the wire = start word, then the payload bytes, one /T/ byte and
  // idle fill up to a word boundary, then IFG idle words.
  function automatic void model_push_frame();
    logic [8:0]  ln[$];
    logic [63:0] w;
    logic [7:0]  c;
    bit          dn;
    exp_q.push_back({2'b00, 8'h01, START_W});
    foreach (pay_q[i]) ln.push_back({1'b0, pay_q[i]});
    ln.push_back({1'b1, 8'hFD});
    while (ln.size() % 8 != 0) ln.push_back({1'b1, 8'h07});
    for (int g = 0; g < ln.size() / 8; g++) begin
      dn = 1'b0;
      for (int l = 0; l < 8; l++) begin
        w[8*l +: 8] = ln[8*g+l][7:0];
        c[l]        = ln[8*g+l][8];
        if (ln[8*g+l] == {1'b1, 8'hFD}) dn = 1'b1;
      end
      exp_q.push_back({1'b0, dn, c, w});
    end
    for (int i = 0; i < IFG; i++) exp_q.push_back(IDLE_E);
  endfunction

  function automatic void gen_frame(input int nbeats, input int keep, input bit do_model);
    logic [63:0] d;
    int          nb;
    bit          last;
    pay_q.delete();
    for (int b = 0; b < nbeats; b++) begin
      d    = {$urandom, $urandom};
      last = (b == nbeats - 1);
      b_data.push_back(d);
      b_keep.push_back(last ? 4'(keep) : 4'($urandom_range(0, 15)));
      b_last.push_back(last);
      nb = !last ? 8 : ((keep == 0 || keep > 8) ? 8 : keep);
      for (int j = 0; j < nb; j++) pay_q.push_back(d[8*j +: 8]);
    end
    if (do_model) model_push_frame();
  endfunction

  function automatic int first_active();
    foreach (got_q[i]) if (got_q[i] !== IDLE_E) return i;
    return -1;
  endfunction

  function automatic void clear_all();
    b_data.delete(); b_keep.delete(); b_last.delete();
    exp_q.delete(); got_q.delete();
    gap_idx = -1;
  endfunction

  task automatic send_beat(input int i);
    int waited = 0;
    s_valid = 1'b1;
    s_data  = b_data[i];
    s_keep  = b_keep[i];
    s_last  = b_last[i];
    forever begin
      @(negedge clk);
      if (s_ready) break;
      waited++;
      if (waited > 50) begin
        checks++; errors++;
        $display("FAIL beat_accept_timeout got=s_ready_low exp=accept_within_50");
        return;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic run_and_capture(input int extra);
    got_q.delete();
    cap_en = 1'b1;
    foreach (b_data[i]) begin
      if (i == gap_idx) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
      send_beat(i);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (extra) @(posedge clk);
    @(negedge clk);
    cap_en = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({xgmii_data, xgmii_ctrl, s_ready, frame_done_o, underrun_o} !== {IDLE_W, 8'hFF, 3'b000}) begin
      errors++;
      $display("FAIL reset_outputs got=%h/%h/%b%b%b exp=%h/ff/000", xgmii_data, xgmii_ctrl,
               s_ready, frame_done_o, underrun_o, IDLE_W);
    end
    rstn = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (xgmii_data !== IDLE_W || xgmii_ctrl !== 8'hFF || s_ready !== 1'b0) begin
        errors++;
        $display("FAIL idle_after_reset cyc=%0d got=%h/%h/%b exp=%h/ff/0", c, xgmii_data,
                 xgmii_ctrl, s_ready, IDLE_W);
      end
    end
  endtask

  task automatic test_keep3();
    int base;
    clear_all();
    gen_frame(3, 3, 1'b1);
    run_and_capture(IFG + 4);
    base = first_active();
    checks++;
    if (base < 0 || base + 3 >= got_q.size() || got_q[base+3][71:64] !== 8'hF8) begin
      errors++;
      $display("FAIL keep3_term_ctrl got=%h exp=f8", (base < 0 || base + 3 >= got_q.size()) ? 8'hxx : got_q[base+3][71:64]);
    end
    foreach (exp_q[i]) begin
      checks++;
      if (base < 0 || base + i >= got_q.size() || got_q[base+i] !== exp_q[i]) begin
        errors++;
        $display("FAIL keep3_word%0d got=%h exp=%h", i, (base < 0 || base + i >= got_q.size()) ? 74'hx : got_q[base+i], exp_q[i]);
      end
    end
  endtask

  task automatic test_single_full();
    int base;
    clear_all();
    gen_frame(1, 8, 1'b1);
    run_and_capture(IFG + 4);
    base = first_active();
    foreach (exp_q[i]) begin
      checks++;
      if (base < 0 || base + i >= got_q.size() || got_q[base+i] !== exp_q[i]) begin
        errors++;
        $display("FAIL single_full_word%0d got=%h exp=%h", i, (base < 0 || base + i >= got_q.size()) ? 74'hx : got_q[base+i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random_frames();
    int base;
    for (int f = 0; f < 6; f++) begin
      clear_all();
      gen_frame($urandom_range(1, 5), $urandom_range(0, 15), 1'b1);
      run_and_capture(IFG + 4);
      base = first_active();
      foreach (exp_q[i]) begin
        checks++;
        if (base < 0 || base + i >= got_q.size() || got_q[base+i] !== exp_q[i]) begin
          errors++;
          $display("FAIL random_f%0d_word%0d got=%h exp=%h", f, i, (base < 0 || base + i >= got_q.size()) ? 74'hx : got_q[base+i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_underrun();
    int base;
    clear_all();
    gen_frame(4, $urandom_range(1, 8), 1'b0);
    gap_idx = 1;
    // Aborted frame: start, first beat, /E/, then idles while the three
    // remaining beats drain, IFG words, and the one IDLE-state word.
    exp_q.push_back({2'b00, 8'h01, START_W});
    exp_q.push_back({2'b00, 8'h00, b_data[0]});
    exp_q.push_back({2'b10, 8'hFF, ERR_W});
    for (int i = 0; i < 3 + IFG + 1; i++) exp_q.push_back(IDLE_E);
    gen_frame(2, $urandom_range(1, 8), 1'b1);
    run_and_capture(IFG + 4);
    base = first_active();
    foreach (exp_q[i]) begin
      checks++;
      if (base < 0 || base + i >= got_q.size() || got_q[base+i] !== exp_q[i]) begin
        errors++;
        $display("FAIL underrun_word%0d got=%h exp=%h", i, (base < 0 || base + i >= got_q.size()) ? 74'hx : got_q[base+i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int base;
    clear_all();
    gen_frame($urandom_range(1, 4), $urandom_range(1, 8), 1'b1);
    exp_q.push_back(IDLE_E);
    gen_frame($urandom_range(1, 4), $urandom_range(1, 8), 1'b1);
    run_and_capture(IFG + 4);
    base = first_active();
    foreach (exp_q[i]) begin
      checks++;
      if (base < 0 || base + i >= got_q.size() || got_q[base+i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_word%0d got=%h exp=%h", i, (base < 0 || base + i >= got_q.size()) ? 74'hx : got_q[base+i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int base;
    @(negedge clk);
    s_valid = 1'b1;
    s_last  = 1'b0;
    s_data  = {$urandom, $urandom};
    s_keep  = 4'd8;
    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (xgmii_ctrl !== 8'h00) begin
      errors++;
      $display("FAIL midframe_pre_reset_ctrl got=%h exp=00", xgmii_ctrl);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if ({xgmii_data, xgmii_ctrl, s_ready, frame_done_o, underrun_o} !== {IDLE_W, 8'hFF, 3'b000}) begin
      errors++;
      $display("FAIL midframe_async_reset got=%h/%h/%b exp=%h/ff/0", xgmii_data, xgmii_ctrl, s_ready, IDLE_W);
    end
    s_valid = 1'b0;
    #3;
    rstn = 1'b1;
    clear_all();
    gen_frame($urandom_range(2, 5), $urandom_range(1, 8), 1'b1);
    run_and_capture(IFG + 4);
    base = first_active();
    foreach (exp_q[i]) begin
      checks++;
      if (base < 0 || base + i >= got_q.size() || got_q[base+i] !== exp_q[i]) begin
        errors++;
        $display("FAIL post_reset_word%0d got=%h exp=%h", i, (base < 0 || base + i >= got_q.size()) ? 74'hx : got_q[base+i], exp_q[i]);
      end
    end
  endtask

  initial begin
    rstn    = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_keep  = '0;
    s_last  = 1'b0;
    test_reset();
    test_keep3();
    test_single_full();
    test_random_frames();
    test_underrun();
    test_back_to_back();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
